cache_ctrl: RTL and testbench

//  Sequencer between the CPU load/store port and the 2-way set-associative Cache array.

---
 rtl/cache_ctrl_pkg.sv | 22 ++
 rtl/cache_ctrl_if.sv | 42 ++++
 rtl/cache_lru_table.sv | 35 +++
 rtl/cache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared widths, FSM state encoding and address-slicing helpers for the cache controller.
package cache_ctrl_pkg;

  localparam int unsigned IndexW       = 5;
  localparam int unsigned OffW         = 5;
  localparam int unsigned DataW        = 32;
  localparam int unsigned WordW        = OffW - 2;
  localparam int unsigned WordsPerLine = 1 << WordW;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StCompare,
    StRefill,
    StWrMem
  } state_e;

  function automatic logic [IndexW-1:0] addr_idx(input logic [31:0] addr);
    return addr[OffW+IndexW-1:OffW];
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU port, cache-array port and memory port of the cache controller as one bundle.
interface cache_ctrl_if;
  import cache_ctrl_pkg::*;

  logic             cpu_req;
  logic             cpu_we;
  logic [31:0]      cpu_addr;
  logic [DataW-1:0] cpu_wdata;
  logic             cpu_ready;
  logic [DataW-1:0] cpu_rdata;

  logic [31:0]      addr_in;
  logic             we;
  logic             sel0;
  logic             sel1;
  logic [DataW-1:0] di0;
  logic [DataW-1:0] di1;
  logic             HIT0;
  logic             HIT1;
  logic [DataW-1:0] dout0;
  logic [DataW-1:0] dout1;

  logic             mem_req;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [DataW-1:0] mem_wdata;
  logic             mem_ack;
  logic [DataW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, HIT0, HIT1, dout0, dout1, mem_ack, mem_rdata,
    output cpu_ready, cpu_rdata, addr_in, we, sel0, sel1, di0, di1,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, HIT0, HIT1, dout0, dout1, mem_ack, mem_rdata,
    input  cpu_ready, cpu_rdata, addr_in, we, sel0, sel1, di0, di1,
           mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_lru_table.sv
// One LRU bit per set; the bit names the way to evict next. Synchronous clear to way 0.
module cache_lru_table #(
  parameter int unsigned IndexW = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [IndexW-1:0] rd_idx_i,
  output logic              rd_bit_o,
  input  logic [IndexW-1:0] wr_idx_i,
  input  logic              wr_bit_i,
  input  logic              wr_en_i
);

  localparam int unsigned Sets = 1 << IndexW;

  logic [Sets-1:0] lru_q, lru_d;

  always_comb begin
    lru_d = lru_q;
    if (wr_en_i) begin
      lru_d[wr_idx_i] = wr_bit_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lru_q <= '0;
    end else begin
      lru_q <= lru_d;
    end
  end

  assign rd_bit_o = lru_q[rd_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// 2-way set-associative cache sequencer: lookup, LRU victim refill on load miss,
// write-through / no-write-allocate stores.
module cache_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             req_we_q, req_we_d;
  logic [31:0]      req_addr_q, req_addr_d;
  logic [DataW-1:0] req_wdata_q, req_wdata_d;
  logic             victim_q, victim_d;
  logic [WordW-1:0] cnt_q, cnt_d;

  logic [IndexW-1:0] set_idx;
  logic              lru_rd;
  logic              lru_we;
  logic              lru_wbit;
  logic [31:0]       refill_addr;
  logic              hit_any;

  assign set_idx     = addr_idx(req_addr_q);
  assign refill_addr = {req_addr_q[31:OffW], cnt_q, 2'b00};
  assign hit_any     = bus.HIT0 | bus.HIT1;

  cache_lru_table #(
    .IndexW (IndexW)
  ) u_lru (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .rd_idx_i (set_idx),
    .rd_bit_o (lru_rd),
    .wr_idx_i (set_idx),
    .wr_bit_i (lru_wbit),
    .wr_en_i  (lru_we)
  );

  always_comb begin
    state_d     = state_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    victim_d    = victim_q;
    cnt_d       = cnt_q;
    lru_we      = 1'b0;
    lru_wbit    = 1'b0;

    bus.cpu_ready = 1'b0;
    bus.cpu_rdata = '0;
    bus.addr_in   = '0;
    bus.we        = 1'b0;
    bus.sel0      = 1'b0;
    bus.sel1      = 1'b0;
    bus.di0       = '0;
    bus.di1       = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req) begin
          req_we_d    = bus.cpu_we;
          req_addr_d  = bus.cpu_addr;
          req_wdata_d = bus.cpu_wdata;
          state_d     = StLookup;
        end
      end

      StLookup: begin
        bus.addr_in = req_addr_q;
        state_d     = StCompare;
      end

      StCompare: begin
        // Address stays on the array so a store hit can write this cycle.
        bus.addr_in = req_addr_q;
        if (hit_any) begin
          // Way 0 wins if both ways claim a hit.
          lru_we   = 1'b1;
          lru_wbit = bus.HIT0;
        end
        if (!req_we_q) begin
          if (hit_any) begin
            bus.cpu_ready = 1'b1;
            bus.cpu_rdata = bus.HIT0 ? bus.dout0 : bus.dout1;
            state_d       = StIdle;
          end else begin
            victim_d = lru_rd;
            cnt_d    = '0;
            state_d  = StRefill;
          end
        end else begin
          if (hit_any) begin
            bus.we   = 1'b1;
            bus.sel0 = bus.HIT0;
            bus.sel1 = !bus.HIT0;
            bus.di0  = bus.HIT0 ? req_wdata_q : '0;
            bus.di1  = bus.HIT0 ? '0 : req_wdata_q;
          end
          state_d = StWrMem;
        end
      end

      StRefill: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = refill_addr;
        bus.addr_in  = refill_addr;
        if (bus.mem_ack) begin
          bus.we   = 1'b1;
          bus.sel0 = !victim_q;
          bus.sel1 = victim_q;
          bus.di0  = victim_q ? '0 : bus.mem_rdata;
          bus.di1  = victim_q ? bus.mem_rdata : '0;
          cnt_d    = cnt_q + WordW'(1);
          if (cnt_q == WordW'(WordsPerLine - 1)) begin
            lru_we   = 1'b1;
            lru_wbit = !victim_q;
            state_d  = StLookup;
          end
        end
      end

      StWrMem: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = req_addr_q;
        bus.mem_wdata = req_wdata_q;
        if (bus.mem_ack) begin
          bus.cpu_ready = 1'b1;
          state_d       = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      victim_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      victim_q    <= victim_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural 2-way cache array and a memory responder.
module tb_cache_ctrl;
  import cache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_if bus ();

  cache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    int          nwe;
    int          nsel0;
    int          nsel1;
    logic        lru8;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } vec_t;

  vec_t vecs [11];
  logic rst_hit;

  // Cache array model: per-word valid bits, hit/data registered one cycle after addr_in.
  logic [21:0] tag0_m [32];
  logic [21:0] tag1_m [32];
  logic [7:0]  vld0_m [32] = '{default: '0};
  logic [7:0]  vld1_m [32] = '{default: '0};
  logic [31:0] dat0_m [256];
  logic [31:0] dat1_m [256];
  logic [4:0]  c_set;
  logic [2:0]  c_word;
  logic [21:0] c_tag;

  assign c_set  = bus.addr_in[9:5];
  assign c_word = bus.addr_in[4:2];
  assign c_tag  = bus.addr_in[31:10];

  always @(posedge clk) begin
    bus.HIT0  <= vld0_m[c_set][c_word] && (tag0_m[c_set] == c_tag);
    bus.HIT1  <= vld1_m[c_set][c_word] && (tag1_m[c_set] == c_tag);
    bus.dout0 <= dat0_m[{c_set, c_word}];
    bus.dout1 <= dat1_m[{c_set, c_word}];
    if (bus.we && bus.sel0) begin
      if (vld0_m[c_set] == 8'd0 || tag0_m[c_set] != c_tag) begin
        tag0_m[c_set] <= c_tag;
        vld0_m[c_set] <= 8'd1 << c_word;
      end else begin
        vld0_m[c_set] <= vld0_m[c_set] | (8'd1 << c_word);
      end
      dat0_m[{c_set, c_word}] <= bus.di0;
    end
    if (bus.we && bus.sel1) begin
      if (vld1_m[c_set] == 8'd0 || tag1_m[c_set] != c_tag) begin
        tag1_m[c_set] <= c_tag;
        vld1_m[c_set] <= 8'd1 << c_word;
      end else begin
        vld1_m[c_set] <= vld1_m[c_set] | (8'd1 << c_word);
      end
      dat1_m[{c_set, c_word}] <= bus.di1;
    end
  end

  // Memory returns (addr/4 - 54): 0x100..0x11C read back as 10..17.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a >> 2) - 32'd54;
  endfunction

  int n_rd = 0, n_wr = 0, n_we = 0, n_s0 = 0, n_s1 = 0, n_both = 0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) begin
      bus.mem_ack   <= 1'b1;
      bus.mem_rdata <= mem_val(bus.mem_addr);
    end else begin
      bus.mem_ack <= 1'b0;
    end
    if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        n_wr         <= n_wr + 1;
        last_wr_addr <= bus.mem_addr;
        last_wr_data <= bus.mem_wdata;
      end else begin
        n_rd <= n_rd + 1;
      end
    end
    if (bus.we) n_we <= n_we + 1;
    if (bus.we && bus.sel0) n_s0 <= n_s0 + 1;
    if (bus.we && bus.sel1) n_s1 <= n_s1 + 1;
    if (bus.sel0 && bus.sel1) n_both <= n_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    bus.cpu_req   = 1'b1;
    lat = 0;
    rd  = '0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.cpu_ready) begin
        lat = i;
        rd  = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    int s_rd = n_rd;
    int s_wr = n_wr;
    int s_we = n_we;
    int s_s0 = n_s0;
    int s_s1 = n_s1;
    logic [31:0] rd;
    int lat;
    do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
    chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
    if (!vecs[i].we) chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
    chk($sformatf("v%0d_mem_reads", i), n_rd - s_rd, vecs[i].nrd);
    chk($sformatf("v%0d_mem_writes", i), n_wr - s_wr, vecs[i].nwr);
    chk($sformatf("v%0d_cache_we", i), n_we - s_we, vecs[i].nwe);
    chk($sformatf("v%0d_sel0", i), n_s0 - s_s0, vecs[i].nsel0);
    chk($sformatf("v%0d_sel1", i), n_s1 - s_s1, vecs[i].nsel1);
    chk($sformatf("v%0d_lru8", i), dut.u_lru.lru_q[8], vecs[i].lru8);
    if (vecs[i].nwr != 0) begin
      chk($sformatf("v%0d_wr_addr", i), last_wr_addr, vecs[i].wr_addr);
      chk($sformatf("v%0d_wr_data", i), last_wr_data, vecs[i].wr_data);
    end
  endtask

  initial begin
    int s_rd;
    int s_s1;
    //          we    addr        wdata  rdata  lat nrd nwr nwe s0 s1 lru8  wr_addr     wr_data
    vecs[0]  = '{1'b0, 32'h0100, 32'd0,  32'd10,   20, 8, 0, 8, 8, 0, 1'b1, 32'h0,   32'd0};
    vecs[1]  = '{1'b0, 32'h0104, 32'd0,  32'd11,    2, 0, 0, 0, 0, 0, 1'b1, 32'h0,   32'd0};
    vecs[2]  = '{1'b1, 32'h0108, 32'd5,  32'd0,     4, 0, 1, 1, 1, 0, 1'b1, 32'h108, 32'd5};
    vecs[3]  = '{1'b0, 32'h0108, 32'd0,  32'd5,     2, 0, 0, 0, 0, 0, 1'b1, 32'h0,   32'd0};
    vecs[4]  = '{1'b1, 32'h0120, 32'd20, 32'd0,     4, 0, 1, 0, 0, 0, 1'b1, 32'h120, 32'd20};
    vecs[5]  = '{1'b0, 32'h2100, 32'd0,  32'd2058, 20, 8, 0, 8, 0, 8, 1'b0, 32'h0,   32'd0};
    vecs[6]  = '{1'b0, 32'h4100, 32'd0,  32'd4106, 20, 8, 0, 8, 8, 0, 1'b1, 32'h0,   32'd0};
    vecs[7]  = '{1'b0, 32'h2104, 32'd0,  32'd2059,  2, 0, 0, 0, 0, 0, 1'b0, 32'h0,   32'd0};
    vecs[8]  = '{1'b0, 32'h4104, 32'd0,  32'd4107,  2, 0, 0, 0, 0, 0, 1'b1, 32'h0,   32'd0};
    vecs[9]  = '{1'b0, 32'h610C, 32'd0,  32'd6157, 20, 8, 0, 8, 8, 0, 1'b1, 32'h0,   32'd0};
    vecs[10] = '{1'b0, 32'h6104, 32'd0,  32'd6155,  2, 0, 0, 0, 0, 0, 1'b1, 32'h0,   32'd0};

    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_zero", 32'(|{bus.cpu_ready, bus.cpu_rdata, bus.addr_in, bus.we, bus.sel0,
        bus.sel1, bus.di0, bus.di1, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 0);
    chk("rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("rst_lru", dut.u_lru.lru_q, 0);
    chk("rst_cnt", 32'(dut.cnt_q), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Set 8 LRU now points at way 1; reset lands on the third refill ack.
    s_rd = n_rd;
    s_s1 = n_s1;
    rst_hit = 1'b0;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'h6100;
    bus.cpu_req  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ack && (n_rd - s_rd) == 2) begin
        rst_hit = 1'b1;
        break;
      end
    end
    chk("mid_rst_third_ack_seen", 32'(rst_hit), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_mem_req", 32'(bus.mem_req), 0);
    chk("mid_rst_state", 32'(dut.state_q), 32'(StIdle));
    chk("mid_rst_lru", dut.u_lru.lru_q, 0);
    chk("mid_rst_cnt", 32'(dut.cnt_q), 0);
    chk("mid_rst_reads", n_rd - s_rd, 3);
    chk("mid_rst_sel1_writes", n_s1 - s_s1, 3);
    bus.cpu_req = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(bus.mem_req | bus.cpu_ready | bus.we), 0);

    for (int i = 9; i < 11; i++) run_vec(i);

    chk("sel_exclusive", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
